io_driver: RTL and testbench

//   Memory-mapped I/O bridge between the CPU port bus and board peripherals:

---
 rtl/io_driver.sv | 121 ++++++++++++
 tb/tb_io_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_driver.sv
// Memory-mapped bridge between the CPU port bus and the board switches, buttons, LEDs and SSD.
// Optional button debounce is enabled by defining IO_BTN_DEBOUNCE_EN.
module io_driver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic [3:0]  btn,
  output logic [3:0]  led,
  output logic [31:0] ssd_bits,
  output logic        ssd_char_mode,
  input  logic        port_read,
  input  logic        port_write,
  input  logic [15:0] port_addr,
  input  logic [15:0] port_write_data,
  output logic [15:0] port_read_data
);

  localparam logic [15:0] ADDR_SW     = 16'hFC00;
  localparam logic [15:0] ADDR_BTN    = 16'hFC01;
  localparam logic [15:0] ADDR_LED    = 16'hFC02;
  localparam logic [15:0] ADDR_SSD_LO = 16'hFC03;
  localparam logic [15:0] ADDR_SSD_HI = 16'hFC04;
  localparam logic [15:0] ADDR_CHAR   = 16'hFC05;

  logic [7:0]  sw_meta_r;
  logic [7:0]  sw_sync_r;
  logic [3:0]  btn_meta_r;
  logic [3:0]  btn_sync_r;
  logic [3:0]  btn_view_s;
  logic [15:0] rd_data_s;

  // Two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= 8'h00;
      sw_sync_r  <= 8'h00;
      btn_meta_r <= 4'h0;
      btn_sync_r <= 4'h0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
    end
  end

`ifdef IO_BTN_DEBOUNCE_EN
  localparam logic [19:0] DEBOUNCE_CYC = 20'd100000;

  logic [19:0] db_cnt_r [4];
  logic [3:0]  btn_db_r;

  // Per-button debounce: a differing input must persist DEBOUNCE_CYC cycles to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= 20'd0;
      end
      btn_db_r <= 4'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_sync_r[i] == btn_db_r[i]) begin
          db_cnt_r[i] <= 20'd0;
        end else if (db_cnt_r[i] == (DEBOUNCE_CYC - 20'd1)) begin
          btn_db_r[i] <= btn_sync_r[i];
          db_cnt_r[i] <= 20'd0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 20'd1;
        end
      end
    end
  end

  assign btn_view_s = btn_db_r;
`else
  assign btn_view_s = btn_sync_r;
`endif

  // Read-data select; unmapped addresses read as zero
  always_comb begin
    rd_data_s = 16'h0000;
    case (port_addr)
      ADDR_SW:     rd_data_s = {8'h00, sw_sync_r};
      ADDR_BTN:    rd_data_s = {12'h000, btn_view_s};
      ADDR_LED:    rd_data_s = {12'h000, led};
      ADDR_SSD_LO: rd_data_s = ssd_bits[15:0];
      ADDR_SSD_HI: rd_data_s = ssd_bits[31:16];
      ADDR_CHAR:   rd_data_s = {15'h0000, ssd_char_mode};
      default:     rd_data_s = 16'h0000;
    endcase
  end

  // Read capture samples pre-write register values, so same-cycle read+write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_read_data <= 16'h0000;
    end else if (port_read) begin
      port_read_data <= rd_data_s;
    end else begin
      port_read_data <= port_read_data;
    end
  end

  // Writable peripheral registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led           <= 4'h0;
      ssd_bits      <= 32'h0000_0000;
      ssd_char_mode <= 1'b0;
    end else if (port_write) begin
      case (port_addr)
        ADDR_LED:    led            <= port_write_data[3:0];
        ADDR_SSD_LO: ssd_bits[15:0] <= port_write_data;
        ADDR_SSD_HI: ssd_bits[31:16] <= port_write_data;
        ADDR_CHAR:   ssd_char_mode  <= port_write_data[0];
        default:     ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_driver.sv
// Scoreboard bench for io_driver: stimulus pushes expected read data, a monitor pops and compares.
module tb_io_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic [3:0]  btn;
  logic [3:0]  led;
  logic [31:0] ssd_bits;
  logic        ssd_char_mode;
  logic        port_read;
  logic        port_write;
  logic [15:0] port_addr;
  logic [15:0] port_write_data;
  logic [15:0] port_read_data;

  io_driver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sw              (sw),
    .btn             (btn),
    .led             (led),
    .ssd_bits        (ssd_bits),
    .ssd_char_mode   (ssd_char_mode),
    .port_read       (port_read),
    .port_write      (port_write),
    .port_addr       (port_addr),
    .port_write_data (port_write_data),
    .port_read_data  (port_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  logic [3:0]  led_m;
  logic [31:0] ssd_m;
  logic        char_m;
  logic [7:0]  sw_m;
  logic [3:0]  btn_m;
  logic        mon_en = 1'b0;
  logic        rd_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference view of the register map
  function automatic logic [15:0] ref_read(input logic [15:0] a);
    case (a)
      16'hFC00: return {8'h00, sw_m};
      16'hFC01: return {12'h000, btn_m};
      16'hFC02: return {12'h000, led_m};
      16'hFC03: return ssd_m[15:0];
      16'hFC04: return ssd_m[31:16];
      16'hFC05: return {15'h0000, char_m};
      default:  return 16'h0000;
    endcase
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [15:0] d);
    case (a)
      16'hFC02: led_m = d[3:0];
      16'hFC03: ssd_m = {ssd_m[31:16], d};
      16'hFC04: ssd_m = {d, ssd_m[15:0]};
      16'hFC05: char_m = d[0];
      default: ;
    endcase
  endtask

  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    #1;
    port_read       = rd;
    port_write      = wr;
    port_addr       = a;
    port_write_data = d;
    if (rd) exp_q.push_back(ref_read(a));
    if (wr) ref_write(a, d);
  endtask

  task automatic idle();
    access(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Change board inputs; a read in the very next cycle must still see the old synchronised value
  task automatic set_inputs(input logic [7:0] s, input logic [3:0] b);
    @(negedge clk);
    #1;
    sw  = s;
    btn = b;
    port_read  = 1'b0;
    port_write = 1'b0;
    access(1'b1, 1'b0, 16'hFC00, 16'h0000);
    sw_m  = s;
    btn_m = b;
    idle();
    idle();
  endtask

  task automatic reset_model();
    led_m  = 4'h0;
    ssd_m  = 32'h0;
    char_m = 1'b0;
  endtask

  always @(posedge clk) rd_d <= port_read & rst_n;

  // Monitor: pop the expected read data and track the register outputs against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_d) begin
        if (exp_q.size() == 0) begin
          chk("read_unexpected", 32'h1, 32'h0);
        end else begin
          chk("read_data", {16'h0, port_read_data}, {16'h0, exp_q.pop_front()});
        end
      end
      chk("led", {28'h0, led}, {28'h0, led_m});
      chk("ssd_bits", ssd_bits, ssd_m);
      chk("ssd_char_mode", {31'h0, ssd_char_mode}, {31'h0, char_m});
    end
  end

  initial begin
    rst_n = 1'b0;
    sw = 8'h00; btn = 4'h0;
    port_read = 1'b0; port_write = 1'b0;
    port_addr = 16'h0000; port_write_data = 16'h0000;
    sw_m = 8'h00; btn_m = 4'h0;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_led", {28'h0, led}, 32'h0);
    chk("rst_ssd", ssd_bits, 32'h0);
    chk("rst_char", {31'h0, ssd_char_mode}, 32'h0);
    chk("rst_rdata", {16'h0, port_read_data}, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // LED write then read back
    access(1'b0, 1'b1, 16'hFC02, 16'h0003);
    access(1'b1, 1'b0, 16'hFC02, 16'h0000);
    idle();
    @(negedge clk);
    chk("dir_led", {28'h0, led}, 32'h3);
    chk("dir_led_read", {16'h0, port_read_data}, 32'h0003);

    // Char mode set and cleared by bit 0 only
    access(1'b0, 1'b1, 16'hFC05, 16'h0001);
    idle();
    chk("dir_char_set", {31'h0, ssd_char_mode}, 32'h1);
    access(1'b0, 1'b1, 16'hFC05, 16'hFFFE);
    idle();
    chk("dir_char_clr", {31'h0, ssd_char_mode}, 32'h0);

    // SSD halves
    access(1'b0, 1'b1, 16'hFC03, 16'h5678);
    access(1'b0, 1'b1, 16'hFC04, 16'h1234);
    idle();
    chk("dir_ssd", ssd_bits, 32'h12345678);

    // Synchronised inputs, ignored writes, unmapped read
    set_inputs(8'h05, 4'h1);
    access(1'b1, 1'b0, 16'hFC00, 16'h0000);
    access(1'b1, 1'b0, 16'hFC01, 16'h0000);
    idle();
    chk("dir_btn_read", {16'h0, port_read_data}, 32'h0001);
    access(1'b0, 1'b1, 16'hFC00, 16'hABCD);
    access(1'b0, 1'b1, 16'hFC01, 16'hFFFF);
    access(1'b1, 1'b0, 16'hFC00, 16'h0000);
    idle();
    chk("dir_sw_after_write", {16'h0, port_read_data}, 32'h0005);
    access(1'b1, 1'b0, 16'd13, 16'h0000);
    idle();
    chk("dir_unmapped", {16'h0, port_read_data}, 32'h0000);

    // Same-cycle read and write of LED
    access(1'b1, 1'b1, 16'hFC02, 16'h0009);
    idle();
    chk("dir_rw_led", {28'h0, led}, 32'h9);
    chk("dir_rw_read", {16'h0, port_read_data}, 32'h0003);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [15:0] a;
      if (i % 60 == 0) set_inputs(8'($urandom), 4'($urandom));
      sel = $urandom_range(0, 7);
      if (sel < 6)       a = 16'hFC00 + 16'(sel);
      else if (sel == 6) a = 16'($urandom);
      else               a = 16'hFC06;
      access(1'($urandom), 1'($urandom), a, 16'($urandom));
    end

    // Asynchronous reset in the middle of a cycle after writes
    access(1'b0, 1'b1, 16'hFC02, 16'h000F);
    access(1'b0, 1'b1, 16'hFC04, 16'hBEEF);
    access(1'b1, 1'b1, 16'hFC05, 16'h0001);
    idle();
    idle();
    @(negedge clk);
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", {28'h0, led}, 32'h0);
    chk("async_rst_ssd", ssd_bits, 32'h0);
    chk("async_rst_char", {31'h0, ssd_char_mode}, 32'h0);
    chk("async_rst_rdata", {16'h0, port_read_data}, 32'h0);
    reset_model();
    sw_m = 8'h00; btn_m = 4'h0;
    sw = 8'h00; btn = 4'h0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    access(1'b1, 1'b0, 16'hFC04, 16'h0000);
    access(1'b1, 1'b0, 16'hFC02, 16'h0000);
    idle();
    idle();
    @(negedge clk);
    mon_en = 1'b0;
    chk("final_queue", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
